mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares tiny8's single memory port between two requesters: the instruction-fetch path and the data (load/store) path of the control unit.
- Grants one requester at a time and alternates grants when both request (round-robin).
- Holds the granted transaction on the memory port until mem_resp, and aborts a hung transaction with a watchdog.
- Sits between the control/datapath and the memory model.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, memory data width
TIMEOUT, 255, max cycles waiting for mem_resp before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
if_read  in  1  fetch read request, held until if_resp
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data, valid when if_resp
if_resp  out  1  fetch completion pulse
d_read  in  1  data read request, held until d_resp
d_write  in  1  data write request, held until d_resp
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  data write data
d_rdata  out  DATA_W  data read data, valid when d_resp
d_resp  out  1  data completion pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_resp  in  1  memory completion, one cycle
timeout_err  out  1  sticky: a transaction was aborted

Behaviour:
- Reset (async, immediate):
  - state=IDLE; last_grant=DATA, so fetch wins the first tie.
  - mem_read=mem_write=0; mem_addr=0; mem_wdata=0.
  - if_resp=d_resp=0; timeout_err=0; counter=0.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE:
  - Requests are sampled at the clock edge.
  - Only fetch requesting -> BUSY_IF. Only data (read or write) requesting -> BUSY_D.
  - Both requesting -> grant the requester opposite to last_grant; update last_grant.
  - Neither requesting -> stay in IDLE.
  - On grant: latch addr/wdata and the op into registers; clear the counter.
- BUSY_x:
  - mem_* outputs are driven only from the latched registers, never combinationally from requester inputs.
  - mem_read=1 for a fetch or data read; mem_write=1 for a data write. Never both.
  - d_read and d_write both asserted is illegal; the write wins.
- Completion:
  - In BUSY_x, a cycle with mem_resp=1 makes x_resp=1 combinationally in that same cycle, with x_rdata=mem_rdata passed through. The state returns to IDLE at that edge.
  - The other requester's resp stays 0.
  - if_rdata/d_rdata outside their resp cycle: hold the last value returned to that requester (registered copy).
- Latency:
  - A request seen in IDLE at edge N puts the strobe on the memory port in cycle N+1.
  - mem_resp in cycle N+k completes the transaction; the earliest next grant is the edge after that cycle.
  - There is at least 1 IDLE cycle between transactions, so the requester must drop its request the cycle after resp.
- Watchdog (TIMEOUT>0):
  - The counter increments each BUSY cycle with mem_resp=0.
  - When the counter reaches TIMEOUT: abort.
    - Pulse x_resp for that cycle with x_rdata = all ones.
    - Set timeout_err. It clears only on rst.
    - Return to IDLE; strobes drop the next cycle.
  - mem_resp arriving in the abort cycle counts as normal completion, not a timeout.
  - The counter width is clog2(TIMEOUT+1); it must not wrap.
- mem_resp while in IDLE is ignored.
- A requester dropping its request mid-transaction is illegal; the transaction completes regardless.

Decomposition:
- tiny8_types package:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_D}
  - arb_req_t enum {REQ_IF, REQ_D}
  - mem_op_t enum {OP_READ, OP_WRITE}
- No sub-module. The watchdog counter and the round-robin pointer are small enough to stay inline.

Test Plan:
- Reset:
  - Stimulus: rst pulse in mid-BUSY_D write.
  - Required: mem_write=0 asynchronously before the next clk; state IDLE; timeout_err=0.
- Lone fetch:
  - Stimulus: if_read=1, if_addr=0x1234 at edge 0; mem_resp with mem_rdata=0xA5 in cycle 3.
  - Required: mem_read=1 and mem_addr=0x1234 from cycle 1; if_resp=1 and if_rdata=0xA5 in cycle 3; d_resp=0.
- Tie after reset:
  - Stimulus: if_read and d_write (addr 0x0010, wdata 0x3C) both asserted in IDLE.
  - Required: fetch granted first; after its resp and one IDLE cycle, mem_write=1, mem_addr=0x0010, mem_wdata=0x3C.
- Round-robin:
  - Stimulus: both requesters continuously re-request (each dropping its request one cycle after its resp) for 6 transactions, mem_resp 1 cycle after each strobe.
  - Required: grant order IF,D,IF,D,IF,D.
- Watchdog:
  - Stimulus: TIMEOUT=4; d_read with mem_resp held 0.
  - Required: d_resp=1 with d_rdata=0xFF when the counter reaches 4; timeout_err=1 and it stays set; the next fetch completes normally.
- Conflict:
  - Stimulus: d_read=d_write=1.
  - Required: mem_write=1, mem_read=0.

Source files
------------

// File: rtl/tiny8_types.sv
// Shared type definitions for the tiny8 memory arbiter.
package tiny8_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_IF,
        ARB_BUSY_D
    } arb_state_t;

    typedef enum logic {
        REQ_IF,
        REQ_D
    } arb_req_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing tiny8's single memory port between the fetch
// and data paths, with a per-transaction watchdog.
module mem_arbiter
    import tiny8_types::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t        state_q, state_d;
    arb_req_t          last_grant_q, last_grant_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              if_req, d_req;
    logic              grant, abort;

    assign if_req    = if_read;
    assign d_req     = d_read | d_write;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        grant        = 1'b0;
        if_resp      = 1'b0;
        d_resp       = 1'b0;
        if_rdata     = if_rdata_q;
        d_rdata      = d_rdata_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        // A real response in the abort cycle takes precedence over the timeout
        abort        = (TIMEOUT > 0) && (cnt_q == CNT_MAX) && !mem_resp;

        unique case (state_q)
            ARB_IDLE: begin
                if (if_req && (!d_req || last_grant_q == REQ_D)) begin
                    state_d      = ARB_BUSY_IF;
                    last_grant_d = REQ_IF;
                    op_d         = OP_READ;
                    grant        = 1'b1;
                end else if (d_req) begin
                    state_d      = ARB_BUSY_D;
                    last_grant_d = REQ_D;
                    op_d         = d_write ? OP_WRITE : OP_READ;
                    grant        = 1'b1;
                end
            end
            ARB_BUSY_IF: begin
                mem_read = 1'b1;
                if (mem_resp || abort) begin
                    if_resp  = 1'b1;
                    if_rdata = mem_resp ? mem_rdata : '1;
                    state_d  = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                mem_read  = (op_q == OP_READ);
                mem_write = (op_q == OP_WRITE);
                if (mem_resp || abort) begin
                    d_resp  = 1'b1;
                    d_rdata = mem_resp ? mem_rdata : '1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= REQ_D;
            op_q         <= OP_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            timeout_err  <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (grant) begin
                op_q    <= op_d;
                addr_q  <= (last_grant_d == REQ_IF) ? if_addr : d_addr;
                wdata_q <= d_wdata;
                cnt_q   <= '0;
            end else if ((TIMEOUT > 0) && (state_q != ARB_IDLE) && !mem_resp
                         && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (abort && (state_q != ARB_IDLE)) begin
                timeout_err <= 1'b1;
            end
            if (if_resp) begin
                if_rdata_q <= if_rdata;
            end
            if (d_resp) begin
                d_rdata_q <= d_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_read;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_resp;
    logic          timeout_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_read(if_read), .if_addr(if_addr), .if_rdata(if_rdata), .if_resp(if_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_read   = 1'b0;
        if_addr   = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if ({mem_read, mem_write, if_resp, d_resp, timeout_err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {mem_read, mem_write, if_resp, d_resp, timeout_err});
        end
        n_vec++;
        if ({mem_addr, mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        d_write = 1'b1; d_addr = 16'h55AA; d_wdata = 8'h77;
        tick();
        #1;
        n_vec++;
        if (mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_write: got %b want 1", mem_write);
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({mem_write, mem_read, timeout_err} !== 3'b000 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL reset_async: got wr %b rd %b err %b addr %h want 0",
                     mem_write, mem_read, timeout_err, mem_addr);
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        #1;
        n_vec++;
        if ({mem_read, mem_write, d_resp, if_resp} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_idle_after: got %b want 0000",
                     {mem_read, mem_write, d_resp, if_resp});
        end
    endtask

    task automatic test_lone_fetch();
        do_reset();
        if_read = 1'b1; if_addr = 16'h1234;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin mem_resp = 1'b1; mem_rdata = 8'hA5; end
            #1;
            n_vec++;
            if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 16'h1234) begin
                n_err++;
                $display("FAIL fetch_strobe c%0d: got rd %b wr %b addr %h want 1 0 1234",
                         c, mem_read, mem_write, mem_addr);
            end
            n_vec++;
            if ({if_resp, d_resp} !== {c == 3, 1'b0}) begin
                n_err++;
                $display("FAIL fetch_resp c%0d: got if %b d %b want %b 0", c, if_resp, d_resp, c == 3);
            end
        end
        n_vec++;
        if (if_rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL fetch_rdata: got %h want a5", if_rdata);
        end
        tick();
        mem_resp = 1'b0; if_read = 1'b0; mem_rdata = 8'h00;
        #1;
        n_vec++;
        if (if_resp !== 1'b0 || mem_read !== 1'b0 || if_rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL fetch_after: got resp %b rd %b rdata %h want 0 0 a5",
                     if_resp, mem_read, if_rdata);
        end
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        if_read = 1'b1; if_addr = 16'h0200;
        d_write = 1'b1; d_addr = 16'h0010; d_wdata = 8'h3C;
        tick();
        mem_resp = 1'b1; mem_rdata = 8'h11;
        #1;
        n_vec++;
        if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 16'h0200 ||
            {if_resp, d_resp} !== 2'b10) begin
            n_err++;
            $display("FAIL tie_first: got rd %b wr %b addr %h if %b d %b want 1 0 0200 1 0",
                     mem_read, mem_write, mem_addr, if_resp, d_resp);
        end
        tick();
        mem_resp = 1'b0; if_read = 1'b0;
        #1;
        n_vec++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_err++;
            $display("FAIL tie_gap: got rd %b wr %b want 0 0", mem_read, mem_write);
        end
        tick();
        mem_resp = 1'b1;
        #1;
        n_vec++;
        if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 16'h0010 ||
            mem_wdata !== 8'h3C || d_resp !== 1'b1) begin
            n_err++;
            $display("FAIL tie_second: got rd %b wr %b addr %h wdata %h dresp %b want 0 1 0010 3c 1",
                     mem_read, mem_write, mem_addr, mem_wdata, d_resp);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        bit exp_if;
        do_reset();
        if_addr = 16'hF00D; d_addr = 16'hBEEF;
        if_read = 1'b1; d_read = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_if = (t % 2 == 0);
            tick();
            if_read = 1'b1; d_read = 1'b1;
            mem_resp = 1'b1; mem_rdata = 8'($urandom);
            #1;
            n_vec++;
            if (mem_addr !== (exp_if ? 16'hF00D : 16'hBEEF) || {if_resp, d_resp} !== {exp_if, !exp_if}) begin
                n_err++;
                $display("FAIL rr_order t%0d: got addr %h if %b d %b want fetch=%b",
                         t, mem_addr, if_resp, d_resp, exp_if);
            end
            tick();
            mem_resp = 1'b0;
            if (exp_if) if_read = 1'b0; else d_read = 1'b0;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        // response lands exactly in the abort cycle: normal completion
        d_read = 1'b1; d_addr = 16'h4321;
        for (int k = 0; k <= TMO; k++) begin
            tick();
            mem_resp = (k == TMO); mem_rdata = 8'h42;
            #1;
            n_vec++;
            if (d_resp !== (k == TMO)) begin
                n_err++;
                $display("FAIL wd_edge_resp k%0d: got %b want %b", k, d_resp, k == TMO);
            end
        end
        n_vec++;
        if (d_rdata !== 8'h42) begin
            n_err++;
            $display("FAIL wd_edge_rdata: got %h want 42", d_rdata);
        end
        tick();
        d_read = 1'b0; mem_resp = 1'b0;
        #1;
        n_vec++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL wd_edge_err: got %b want 0", timeout_err);
        end
        // hung transaction
        d_read = 1'b1;
        for (int k = 0; k <= TMO; k++) begin
            tick();
            #1;
            n_vec++;
            if ({d_resp, if_resp, timeout_err} !== {k == TMO, 1'b0, 1'b0} || mem_read !== 1'b1) begin
                n_err++;
                $display("FAIL wd_hung k%0d: got dresp %b ifresp %b err %b rd %b want %b 0 0 1",
                         k, d_resp, if_resp, timeout_err, mem_read, k == TMO);
            end
        end
        n_vec++;
        if (d_rdata !== 8'hFF) begin
            n_err++;
            $display("FAIL wd_abort_rdata: got %h want ff", d_rdata);
        end
        tick();
        d_read = 1'b0;
        #1;
        n_vec++;
        if (timeout_err !== 1'b1 || mem_read !== 1'b0 || d_rdata !== 8'hFF) begin
            n_err++;
            $display("FAIL wd_after: got err %b rd %b rdata %h want 1 0 ff", timeout_err, mem_read, d_rdata);
        end
        if_read = 1'b1; if_addr = 16'h0ABC;
        tick();
        tick();
        mem_resp = 1'b1; mem_rdata = 8'h5E;
        #1;
        n_vec++;
        if (if_resp !== 1'b1 || if_rdata !== 8'h5E || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL wd_next_fetch: got resp %b rdata %h err %b want 1 5e 1", if_resp, if_rdata, timeout_err);
        end
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL wd_sticky: got %b want 1", timeout_err);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0777; d_wdata = 8'h99;
        tick();
        #1;
        n_vec++;
        if ({mem_read, mem_write} !== 2'b01 || mem_wdata !== 8'h99 || mem_addr !== 16'h0777) begin
            n_err++;
            $display("FAIL conflict: got rd %b wr %b wdata %h addr %h want 0 1 99 0777",
                     mem_read, mem_write, mem_wdata, mem_addr);
        end
        mem_resp = 1'b1;
        #1;
        n_vec++;
        if (d_resp !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_resp: got %b want 1", d_resp);
        end
        tick();
        idle_inputs();
    endtask

    // Transaction model: grant by round-robin rule, completion after
    // min(response delay, TMO) busy cycles, all-ones data on timeout.
    task automatic test_random();
        bit            lg_d, exp_err, pend_if, pend_d, g_if, drd, dwr, done, to;
        logic [DW-1:0] hold_if, hold_d, exp_rd, exp_wd;
        logic [AW-1:0] exp_addr;
        int            dly, kind;
        lg_d = 1'b1; exp_err = 1'b0; hold_if = '0; hold_d = '0;
        do_reset();
        for (int r = 0; r < 80; r++) begin
            pend_if = 1'($urandom_range(0, 1));
            pend_d  = 1'($urandom_range(0, 1));
            if (!pend_if && !pend_d) pend_d = 1'b1;
            kind = $urandom_range(0, 4);
            drd = (kind <= 1) || (kind == 4);
            dwr = (kind >= 2);
            if_addr = AW'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom);
            while (pend_if || pend_d) begin
                if_read = pend_if; d_read = pend_d & drd; d_write = pend_d & dwr;
                mem_resp = 1'($urandom_range(0, 1)); mem_rdata = DW'($urandom);
                #1;
                n_vec++;
                if ({if_resp, d_resp, mem_read, mem_write} !== 4'b0 || timeout_err !== exp_err) begin
                    n_err++;
                    $display("FAIL rnd_idle r%0d: got %b err %b want 0000 err %b",
                             r, {if_resp, d_resp, mem_read, mem_write}, timeout_err, exp_err);
                end
                g_if = pend_if && (!pend_d || lg_d);
                lg_d = !g_if;
                exp_addr = g_if ? if_addr : d_addr;
                exp_wd = d_wdata;
                dly = $urandom_range(0, TMO + 2);
                done = 1'b0;
                for (int k = 0; k <= TMO && !done; k++) begin
                    tick();
                    if (!pend_if) if_addr = AW'($urandom);
                    if (!pend_d) begin d_addr = AW'($urandom); d_wdata = DW'($urandom); end
                    mem_resp = (k == dly); mem_rdata = DW'($urandom);
                    #1;
                    done   = (k == dly) || (k == TMO);
                    to     = (k == TMO) && (k != dly);
                    exp_rd = (k == dly) ? mem_rdata : '1;
                    n_vec++;
                    if ({mem_read, mem_write} !== {g_if || !dwr, !g_if && dwr} || mem_addr !== exp_addr ||
                        (!g_if && dwr && mem_wdata !== exp_wd)) begin
                        n_err++;
                        $display("FAIL rnd_port r%0d k%0d: got rd %b wr %b addr %h wd %h want fetch=%b write=%b addr %h wd %h",
                                 r, k, mem_read, mem_write, mem_addr, mem_wdata, g_if, dwr, exp_addr, exp_wd);
                    end
                    n_vec++;
                    if ({if_resp, d_resp} !== {done && g_if, done && !g_if} || timeout_err !== exp_err) begin
                        n_err++;
                        $display("FAIL rnd_resp r%0d k%0d: got if %b d %b err %b want %b %b err %b",
                                 r, k, if_resp, d_resp, timeout_err, done && g_if, done && !g_if, exp_err);
                    end
                    if (done && g_if) hold_if = exp_rd;
                    if (done && !g_if) hold_d = exp_rd;
                    n_vec++;
                    if (if_rdata !== hold_if || d_rdata !== hold_d) begin
                        n_err++;
                        $display("FAIL rnd_rdata r%0d k%0d: got if %h d %h want if %h d %h",
                                 r, k, if_rdata, d_rdata, hold_if, hold_d);
                    end
                    exp_err = exp_err | to;
                end
                tick();
                mem_resp = 1'b0;
                if (g_if) pend_if = 1'b0; else pend_d = 1'b0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_lone_fetch();
        test_tie_after_reset();
        test_round_robin();
        test_watchdog();
        test_conflict();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
